// File: rtl/instr_fetch_rv.sv
// Instruction fetch unit for the RV32I core.
// It fetches one word at a time over a req/ack handshake and holds it for the
// decoder until the pipeline marks it taken. It then computes the next PC from
// the decoder's next-PC source and halts on an illegal instruction or on a
// misaligned target.
module instr_fetch_rv #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_taken,
    input  logic        illegal_n,
    input  logic [1:0]  next_pc_src,
    input  logic [19:0] next_pc_imm20,
    input  logic [11:0] next_pc_imm12,
    input  logic [31:0] jalr_base,
    input  logic        alu_result0,
    input  logic        branch_inverted,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    // Next-PC source encoding shared with the decoder
    localparam logic [1:0] NEXT_PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] NEXT_PC_SRC_JAL    = 2'd1;
    localparam logic [1:0] NEXT_PC_SRC_BRANCH = 2'd2;
    localparam logic [1:0] NEXT_PC_SRC_JALR   = 2'd3;

    localparam logic [1:0] HALT_NONE       = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL    = 2'd1;
    localparam logic [1:0] HALT_MISALIGNED = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] jal_offset;
    logic [31:0] branch_offset;
    logic [31:0] jalr_sum;
    logic        branch_taken;
    logic [31:0] next_pc;

    // The fetch address is always the current PC; it is stable while a request is open
    assign imem_addr = pc;

    // Next PC for the instruction currently held, all arithmetic wraps modulo 2^32
    always_comb begin
        jal_offset    = {{11{next_pc_imm20[19]}}, next_pc_imm20, 1'b0};
        branch_offset = {{19{next_pc_imm12[11]}}, next_pc_imm12, 1'b0};
        jalr_sum      = jalr_base + {{20{next_pc_imm12[11]}}, next_pc_imm12};
        branch_taken  = alu_result0 ^ branch_inverted;
        next_pc       = pc + 32'd4;
        case (next_pc_src)
            NEXT_PC_SRC_SEQ:    next_pc = pc + 32'd4;
            NEXT_PC_SRC_JAL:    next_pc = pc + jal_offset;
            NEXT_PC_SRC_BRANCH: next_pc = branch_taken ? (pc + branch_offset) : (pc + 32'd4);
            NEXT_PC_SRC_JALR:   next_pc = jalr_sum & 32'hFFFF_FFFE;
            default:            next_pc = pc + 32'd4;
        endcase
    end

    // Fetch/issue/halt sequencing with every output registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            halt_cause  <= HALT_NONE;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_data;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!illegal_n) begin
                        halted      <= 1'b1;
                        halt_cause  <= HALT_ILLEGAL;
                        instr_valid <= 1'b0;
                        state       <= S_HALT;
                    end else if (instr_taken) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            halted     <= 1'b1;
                            halt_cause <= HALT_MISALIGNED;
                            state      <= S_HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_rv.sv
// Self-checking bench for instr_fetch_rv.
// A memory responder with a configurable ack delay serves words derived from
// the address. Each issued instruction's successor PC is predicted with plain
// integer arithmetic. A per-cycle compare process checks the DUT against that
// prediction, and literal checks pin the expected PCs of the directed cases.
module tb_instr_fetch_rv;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [1:0]  SRC_SEQ  = 2'd0;
    localparam logic [1:0]  SRC_JAL  = 2'd1;
    localparam logic [1:0]  SRC_BR   = 2'd2;
    localparam logic [1:0]  SRC_JALR = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_taken;
    logic        illegal_n;
    logic [1:0]  next_pc_src;
    logic [19:0] next_pc_imm20;
    logic [11:0] next_pc_imm12;
    logic [31:0] jalr_base;
    logic        alu_result0;
    logic        branch_inverted;
    logic        halted;
    logic [1:0]  halt_cause;

    int          n_compared = 0;
    int          n_failed   = 0;
    int          ack_delay  = 0;
    int          req_cnt    = 0;
    bit          late_ack   = 0;
    bit          check_en   = 0;
    logic [31:0] exp_pc     = RESET_PC;
    logic        exp_halted = 0;
    logic [1:0]  exp_cause  = 0;
    int          waited;

    instr_fetch_rv #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .instr           (instr),
        .pc              (pc),
        .instr_valid     (instr_valid),
        .instr_taken     (instr_taken),
        .illegal_n       (illegal_n),
        .next_pc_src     (next_pc_src),
        .next_pc_imm20   (next_pc_imm20),
        .next_pc_imm12   (next_pc_imm12),
        .jalr_base       (jalr_base),
        .alu_result0     (alu_result0),
        .branch_inverted (branch_inverted),
        .halted          (halted),
        .halt_cause      (halt_cause)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: a known instruction at the reset PC, address-derived words elsewhere
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Successor PC computed from signed integer offsets
    function automatic logic [31:0] npc_model(input logic [31:0] cur, input logic [1:0] src,
                                              input logic [19:0] i20, input logic [11:0] i12,
                                              input logic [31:0] base, input logic a0,
                                              input logic inv);
        int          off;
        logic [31:0] t;
        case (src)
            SRC_JAL: begin
                off = int'(i20);
                if (off >= 524288) off = off - 1048576;
                return cur + 32'(off * 2);
            end
            SRC_BR: begin
                if (a0 == inv) return cur + 32'd4;
                off = int'(i12);
                if (off >= 2048) off = off - 4096;
                return cur + 32'(off * 2);
            end
            SRC_JALR: begin
                off = int'(i12);
                if (off >= 2048) off = off - 4096;
                t = base + 32'(off);
                t[0] = 1'b0;
                return t;
            end
            default: return cur + 32'd4;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!instr_valid && cycles < 50) begin
            step();
            cycles++;
        end
        if (!instr_valid) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL wait_valid: got timeout after %0d cycles, expected instr_valid", cycles);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        exp_pc     = RESET_PC;
        exp_halted = 1'b0;
        exp_cause  = 2'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Present one instruction's decoder outcome for one cycle and advance the model
    task automatic apply_stimulus(input logic [1:0] src, input logic [19:0] i20,
                                  input logic [11:0] i12, input logic [31:0] base,
                                  input logic a0, input logic inv, input logic ill_n);
        int          c;
        logic [31:0] nxt;
        wait_valid(c);
        next_pc_src     = src;
        next_pc_imm20   = i20;
        next_pc_imm12   = i12;
        jalr_base       = base;
        alu_result0     = a0;
        branch_inverted = inv;
        illegal_n       = ill_n;
        instr_taken     = 1'b1;
        nxt = npc_model(exp_pc, src, i20, i12, base, a0, inv);
        step();
        instr_taken = 1'b0;
        illegal_n   = 1'b1;
        if (!ill_n) begin
            exp_halted = 1'b1;
            exp_cause  = 2'd1;
        end else if (nxt[1:0] != 2'b00) begin
            exp_pc     = nxt;
            exp_halted = 1'b1;
            exp_cause  = 2'd2;
        end else begin
            exp_pc = nxt;
        end
    endtask

    // Memory responder: acks after ack_delay request cycles, or forces a stray ack
    initial begin
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        forever begin
            @(negedge clk);
            if (late_ack) begin
                imem_ack  = 1'b1;
                imem_data = 32'hBAD0_BAD0;
            end else if (imem_req) begin
                if (req_cnt >= ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = word_at(imem_addr);
                end else begin
                    imem_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                imem_ack = 1'b0;
                req_cnt  = 0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model state
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check_output("pc", pc, exp_pc);
                check_output("imem_addr", imem_addr, exp_pc);
                check_output("halted", 32'(halted), 32'(exp_halted));
                check_output("halt_cause", 32'(halt_cause), 32'(exp_cause));
                check_output("req_and_valid", 32'(imem_req & instr_valid), 32'd0);
                if (instr_valid) check_output("instr", instr, word_at(exp_pc));
                if (exp_halted) check_output("halt_quiet", {30'd0, imem_req, instr_valid}, 32'd0);
            end
        end
    end

    // Directed scenario sequence
    initial begin
        rst_n = 1'b0;
        instr_taken = 0; illegal_n = 1; next_pc_src = SRC_SEQ; next_pc_imm20 = 0;
        next_pc_imm12 = 0; jalr_base = 0; alu_result0 = 0; branch_inverted = 0;
        check_en = 1'b1;
        ack_delay = 3;
        do_reset();
        check_output("reset_valid", 32'(instr_valid), 32'd0);
        check_output("reset_instr", instr, 32'h0000_0013);
        wait_valid(waited);
        check_output("first_fetch_latency", 32'(waited), 32'd5);
        check_output("first_instr", instr, 32'h0050_0093);
        check_output("first_pc", pc, 32'h100);

        ack_delay = 0;
        apply_stimulus(SRC_SEQ, 0, 0, 0, 0, 0, 1);
        check_output("seq_pc", pc, 32'h104);
        check_output("seq_req", 32'(imem_req), 32'd1);
        wait_valid(waited);
        check_output("cadence", 32'(waited + 1), 32'd2);

        apply_stimulus(SRC_JALR, 0, 12'h000, 32'h200, 0, 0, 1);
        apply_stimulus(SRC_BR, 0, 12'hFFE, 0, 1, 0, 1);
        check_output("br_taken", pc, 32'h1FC);
        apply_stimulus(SRC_JALR, 0, 12'h000, 32'h200, 0, 0, 1);
        apply_stimulus(SRC_BR, 0, 12'hFFE, 0, 0, 0, 1);
        check_output("br_not_taken", pc, 32'h204);
        apply_stimulus(SRC_JALR, 0, 12'h000, 32'h200, 0, 0, 1);
        apply_stimulus(SRC_BR, 0, 12'hFFE, 0, 1, 1, 1);
        check_output("br_inv_not_taken", pc, 32'h204);
        apply_stimulus(SRC_JALR, 0, 12'h000, 32'h200, 0, 0, 1);
        apply_stimulus(SRC_BR, 0, 12'hFFE, 0, 0, 1, 1);
        check_output("br_inv_taken", pc, 32'h1FC);

        apply_stimulus(SRC_JALR, 0, 12'h000, 32'h40, 0, 0, 1);
        apply_stimulus(SRC_JAL, 20'h00010, 0, 0, 0, 0, 1);
        check_output("jal", pc, 32'h60);
        apply_stimulus(SRC_JALR, 0, 12'h003, 32'h1001, 0, 0, 1);
        check_output("jalr", pc, 32'h1004);
        apply_stimulus(SRC_JALR, 0, 12'h000, 32'hFFFF_FFFC, 0, 0, 1);
        apply_stimulus(SRC_SEQ, 0, 0, 0, 0, 0, 1);
        check_output("seq_wrap", pc, 32'h0);
        check_output("seq_wrap_not_halted", 32'(halted), 32'd0);

        apply_stimulus(SRC_SEQ, 0, 0, 0, 0, 0, 0);
        repeat (5) step();
        check_output("illegal_halted", 32'(halted), 32'd1);
        check_output("illegal_cause", 32'(halt_cause), 32'd1);
        check_output("illegal_pc", pc, 32'h0);
        check_output("illegal_req", 32'(imem_req), 32'd0);

        do_reset();
        apply_stimulus(SRC_JAL, 20'h00001, 0, 0, 0, 0, 1);
        repeat (3) step();
        check_output("misaligned_pc", pc, 32'h102);
        check_output("misaligned_cause", 32'(halt_cause), 32'd2);

        do_reset();
        ack_delay = 5;
        step();
        step();
        check_output("midfetch_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("reset_drops_req", 32'(imem_req), 32'd0);
        late_ack = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        late_ack = 1'b0;
        ack_delay = 0;
        check_output("late_ack_valid", 32'(instr_valid), 32'd0);
        check_output("late_ack_instr", instr, 32'h0000_0013);
        wait_valid(waited);
        check_output("refetch_instr", instr, 32'h0050_0093);
        check_output("refetch_pc", pc, 32'h100);
        step();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
